s_mem_reader: RTL and testbench
===============================

Name: s_mem_reader

Overview:
- Sequential reader for the 256x8 S-array on-chip RAM; the read-side counterpart of the block that initialises S[i]=i.
- On a start request it scans addresses 0..255 in order and streams each byte out over a valid/ready handshake.
- It also accumulates a mod-256 checksum and, in verify mode, checks every byte against the identity pattern (S[i]==i) and reports mismatches.
- Sits between the S-array RAM port and downstream consumers: debug/HEX display, later RC4 loops, bench checkers.

Parameters:
- ADDR_W, 8, RAM address width; scan covers 0..2^ADDR_W-1.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (legal values 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_flag  in  1  level request; high = run or hold the result, low = abort and return to idle.
- verify_en  in  1  sampled in IDLE when the start is accepted; 1 = compare each byte against its address.
- address  out  ADDR_W  RAM address, registered.
- wren  out  1  RAM write enable; always 0 (drives the shared RAM mux).
- q  in  DATA_W  RAM read data.
- out_data  out  DATA_W  streamed byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the byte.
- busy  out  1  scan in progress.
- done_flag  out  1  scan complete.
- checksum  out  DATA_W  sum of all captured bytes, mod 2^DATA_W.
- err_count  out  ADDR_W+1  verify mismatches; maximum value 256.
- err_flag  out  1  err_count != 0.
- first_err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs 0, including address, out_data, out_valid, busy, done_flag, checksum, err_count, err_flag, first_err_addr. A reset mid-scan aborts it with no further RAM reads.
- States: IDLE, WAIT, HOLD, DONE.
- IDLE, start_flag=1 at an edge:
  - idx=0, address<=0.
  - checksum, err_count and first_err_addr cleared; verify_en latched.
  - wait counter = RD_LAT; state -> WAIT; busy<=1.
- WAIT:
  - Counter decrements each cycle.
  - The address is presented in cycle A. At the end of cycle A+RD_LAT, q is captured into out_data and checksum += q (wraps mod 2^DATA_W).
  - If latched verify=1 and q != idx: err_count increments (saturates at 256). On the first mismatch, first_err_addr<=idx.
  - State -> HOLD; out_valid<=1.
- HOLD:
  - out_valid and out_data stay stable until out_ready is sampled high.
  - On acceptance: out_valid<=0.
  - If idx == 2^ADDR_W-1: state -> DONE, busy<=0, done_flag<=1.
  - Otherwise: idx+1, address<=idx+1, state -> WAIT.
- DONE: done_flag=1 and checksum/err outputs held while start_flag=1. When start_flag=0: state -> IDLE, done_flag<=0; checksum and err outputs hold until the next start.
- start_flag=0 in WAIT or HOLD: abort on that edge. State -> IDLE, out_valid<=0, busy<=0, done_flag stays 0, address<=0. Partial checksum/err values are held.
- Throughput: one byte per RD_LAT+2 cycles with out_ready held high. With RD_LAT=1, a full 256-byte scan is 768 cycles from start acceptance to the done_flag rise.
- The address index wraps only by terminating at 255; no read beyond 2^ADDR_W-1 is ever issued.
- wren is 0 in every state, including reset.
- Only full-width compare and add; no partial-width arithmetic.

Test Plan:
- RAM preloaded S[i]=i, verify_en=1, out_ready=1, start held high:
  - 256 bytes appear in order 0..255.
  - done_flag rises 768 cycles after start acceptance.
  - checksum=0x80, err_count=0, err_flag=0.
  - wren stays 0 throughout.
- Same RAM but S[0x10]=0xAA and S[0x20]=0x00, verify_en=1:
  - err_count=2, first_err_addr=0x10, err_flag=1.
  - checksum=0x80+0x9A-0x20=0xFA.
- Backpressure: out_ready toggles 0 for 5 cycles on every byte. out_data/out_valid stay stable while stalled, no byte is lost or duplicated, and the final checksum matches the no-stall run.
- Abort: start_flag dropped while streaming byte 100. Next edge gives IDLE, out_valid=0, busy=0, done_flag=0, address=0. A restart begins again at address 0 with a cleared checksum.
- Asynchronous reset asserted mid-WAIT, between clock edges: all outputs are 0 immediately. After release with start_flag=1, a full clean scan completes.
- RD_LAT=2 build with an identity RAM: capture aligns (no off-by-one in the stream), and done_flag rises 1024 cycles after start with out_ready=1.

Source files
------------

// File: rtl/s_mem_reader_if.sv
// rtl/s_mem_reader_if.sv - control, RAM-port and byte-stream bundle for s_mem_reader
//
// Signal groups (directions as seen by the reader, modport master):
//   control : start_flag, verify_en                       (in)
//   RAM     : address, wren (out), q (in)
//   stream  : out_data, out_valid (out), out_ready (in)
//   status  : busy, done_flag, checksum, err_count, err_flag, first_err_addr (out)
// The slave modport is the environment side: the RAM plus the downstream consumer.
interface s_mem_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start_flag;
    logic              verify_en;
    logic [ADDR_W-1:0] address;
    logic              wren;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done_flag;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W:0]   err_count;
    logic              err_flag;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        input  start_flag, verify_en, q, out_ready,
        output address, wren, out_data, out_valid,
        output busy, done_flag, checksum, err_count, err_flag, first_err_addr
    );

    modport slave (
        output start_flag, verify_en, q, out_ready,
        input  address, wren, out_data, out_valid,
        input  busy, done_flag, checksum, err_count, err_flag, first_err_addr
    );
endinterface

// File: rtl/s_mem_reader.sv
// rtl/s_mem_reader.sv - sequential reader/verifier for the S-array RAM
//
// Scans addresses 0..2^ADDR_W-1 once per start, streams each byte over a
// valid/ready handshake, accumulates a mod-2^DATA_W checksum and, in verify
// mode, counts bytes that differ from the identity pattern S[i]==i.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces IDLE and zeroes every output
//   bus   : s_mem_reader_if.master (control, RAM port, stream, status)
//
// RD_LAT is the RAM read latency (1..3). A byte takes RD_LAT+2 cycles with
// out_ready held high: one cycle to present the address, RD_LAT cycles of RAM
// latency, and one HOLD cycle for the handshake.
module s_mem_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    s_mem_reader_if.master  bus
);
    // Width used for the identity compare so neither side is truncated.
    localparam int CMP_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ERR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ERR_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DONE
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [1:0]        cnt_q,      cnt_d;
    logic              verify_q,   verify_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [ADDR_W:0]   err_cnt_q,  err_cnt_d;
    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;

    logic              mismatch;

    // The address register doubles as the scan index, so the compare uses it directly.
    assign mismatch = verify_q && (CMP_W'(bus.q) != CMP_W'(addr_q));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        verify_d    = verify_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        checksum_d  = checksum_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_err_d = first_err_q;

        case (state_q)
            IDLE: begin
                if (bus.start_flag) begin
                    addr_d      = '0;
                    cnt_d       = LAT_INIT;
                    verify_d    = bus.verify_en;
                    checksum_d  = '0;
                    err_cnt_d   = '0;
                    err_flag_d  = 1'b0;
                    first_err_d = '0;
                    busy_d      = 1'b1;
                    state_d     = WAIT;
                end
            end

            WAIT: begin
                if (!bus.start_flag) begin
                    // Abort wins over a capture on the same edge; partial results are kept.
                    addr_d      = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    out_data_d  = bus.q;
                    checksum_d  = checksum_q + bus.q;
                    if (mismatch) begin
                        // err_cnt never wraps back to zero, so zero means "first mismatch".
                        if (err_cnt_q == '0) begin
                            first_err_d = addr_q;
                        end
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_ONE;
                        end
                        err_flag_d = 1'b1;
                    end
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end

            HOLD: begin
                if (!bus.start_flag) begin
                    addr_d      = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b0;
                    state_d     = IDLE;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        cnt_d   = LAT_INIT;
                        state_d = WAIT;
                    end
                end
            end

            DONE: begin
                if (!bus.start_flag) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            verify_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            verify_q    <= verify_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            first_err_q <= first_err_d;
        end
    end

    assign bus.address        = addr_q;
    assign bus.wren           = 1'b0;
    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.busy           = busy_q;
    assign bus.done_flag      = done_q;
    assign bus.checksum       = checksum_q;
    assign bus.err_count      = err_cnt_q;
    assign bus.err_flag       = err_flag_q;
    assign bus.first_err_addr = first_err_q;
endmodule

// File: tb/tb_s_mem_reader.sv
// tb/tb_s_mem_reader.sv - scoreboard bench for s_mem_reader (RD_LAT=1 and RD_LAT=2 instances)
module tb_s_mem_reader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    s_mem_reader_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
    s_mem_reader_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

    s_mem_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.master)
    );
    s_mem_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.master)
    );

    // Synchronous RAM models: one register stage for dut0, two for dut1.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] q0_r, p1_r, q1_r;
    always @(posedge clk) begin
        q0_r <= mem0[if0.address];
        p1_r <= mem1[if1.address];
        q1_r <= p1_r;
    end
    assign if0.q = q0_r;
    assign if1.q = q1_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard queues and stream monitors.
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int  bytes0 = 0;
    int  bytes1 = 0;
    bit  stall0_v = 1'b0;
    logic [7:0] stall0_d;
    bit  wren_hi = 1'b0;

    always @(negedge clk) begin
        if (if0.wren || if1.wren) wren_hi = 1'b1;
        if (stall0_v && if0.out_valid) chk("stall_hold", 32'(if0.out_data), 32'(stall0_d));
        if (if0.out_valid && if0.out_ready) begin
            bytes0++;
            chk("stream0_expected", 32'(exp0.size() > 0), 1);
            if (exp0.size() > 0) chk("stream0_byte", 32'(if0.out_data), 32'(exp0.pop_front()));
        end
        stall0_v = if0.out_valid && !if0.out_ready;
        stall0_d = if0.out_data;
    end

    always @(negedge clk) begin
        if (if1.out_valid && if1.out_ready) begin
            bytes1++;
            chk("stream1_expected", 32'(exp1.size() > 0), 1);
            if (exp1.size() > 0) chk("stream1_byte", 32'(if1.out_data), 32'(exp1.pop_front()));
        end
    end

    // out_ready driver for dut0: 0 always ready, 1 five stall cycles per byte,
    // 2 random, 3 stall on byte 100 (identity image) to set up the abort.
    int rmode0 = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rmode0)
            0: if0.out_ready = 1'b1;
            1: begin
                if (!if0.out_valid) begin
                    if0.out_ready = 1'b0;
                    stall_cnt = 0;
                end else if (stall_cnt < 5) begin
                    if0.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    if0.out_ready = 1'b1;
                end
            end
            2: if0.out_ready = 1'($urandom_range(0, 1));
            default: if0.out_ready = !(if0.out_valid && if0.out_data == 8'd100);
        endcase
    end

    // Reference model: expected stream, checksum and verify results from the image.
    int e_sum, e_err, e_first;
    task automatic prep0(input bit ver);
        int s, e, f;
        s = 0; e = 0; f = 0;
        exp0.delete();
        bytes0 = 0;
        for (int i = 0; i < 256; i++) begin
            exp0.push_back(mem0[i]);
            s += int'(mem0[i]);
            if (ver && int'(mem0[i]) != i) begin
                if (e == 0) f = i;
                e++;
            end
        end
        e_sum   = s % 256;
        e_err   = (e > 256) ? 256 : e;
        e_first = f;
    endtask

    task automatic start0(input bit ver, output int t0);
        @(posedge clk); #1;
        if0.verify_en  = ver;
        if0.start_flag = 1'b1;
        t0 = cyc;
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_address"},   32'(if0.address), 0);
        chk({tag, "_out_data"},  32'(if0.out_data), 0);
        chk({tag, "_out_valid"}, 32'(if0.out_valid), 0);
        chk({tag, "_busy"},      32'(if0.busy), 0);
        chk({tag, "_done"},      32'(if0.done_flag), 0);
        chk({tag, "_checksum"},  32'(if0.checksum), 0);
        chk({tag, "_err_count"}, 32'(if0.err_count), 0);
        chk({tag, "_err_flag"},  32'(if0.err_flag), 0);
        chk({tag, "_first_err"}, 32'(if0.first_err_addr), 0);
        chk({tag, "_wren"},      32'(if0.wren), 0);
    endtask

    // Acceptance happens on the edge after t0; checks the scan through DONE and back to IDLE.
    task automatic finish0(input string tag, input int t0, input bit ver, input int bound, output int lat);
        int n;
        @(posedge clk); #1;
        chk({tag, "_busy_after_start"}, 32'(if0.busy), 1);
        chk({tag, "_sum_cleared"},      32'(if0.checksum), 0);
        chk({tag, "_addr_start"},       32'(if0.address), 0);
        if0.verify_en = !ver;
        n = 0;
        while (!if0.done_flag && n < bound) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - t0 - 1;
        chk({tag, "_done_seen"},  32'(if0.done_flag), 1);
        chk({tag, "_busy_done"},  32'(if0.busy), 0);
        chk({tag, "_checksum"},   32'(if0.checksum), e_sum);
        chk({tag, "_err_count"},  32'(if0.err_count), e_err);
        chk({tag, "_err_flag"},   32'(if0.err_flag), 32'(e_err != 0));
        chk({tag, "_first_err"},  32'(if0.first_err_addr), e_first);
        chk({tag, "_bytes"},      bytes0, 256);
        chk({tag, "_queue_left"}, exp0.size(), 0);
        @(posedge clk); #1;
        if0.start_flag = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_clear"}, 32'(if0.done_flag), 0);
        chk({tag, "_sum_held"},   32'(if0.checksum), e_sum);
        chk({tag, "_err_held"},   32'(if0.err_count), e_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, lat, n, s;
        bit ver;
        reset = 1'b0;
        if0.start_flag = 1'b0; if0.verify_en = 1'b0;
        if1.start_flag = 1'b0; if1.verify_en = 1'b0; if1.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'(i);
            mem1[i] = 8'(i);
        end
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero0("reset");
        chk("reset_dut1_busy", 32'(if1.busy), 0);
        reset = 1'b0;

        // Identity image, no stall: latency and clean verify.
        rmode0 = 0;
        prep0(1'b1);
        start0(1'b1, t0);
        finish0("ident", t0, 1'b1, 2000, lat);
        chk("ident_latency", lat, 768);

        // Two corrupted bytes.
        mem0[8'h10] = 8'hAA;
        mem0[8'h20] = 8'h00;
        prep0(1'b1);
        start0(1'b1, t0);
        finish0("errs", t0, 1'b1, 2000, lat);

        // Identity image under five-cycle backpressure on every byte.
        for (int i = 0; i < 256; i++) mem0[i] = 8'(i);
        rmode0 = 1;
        prep0(1'b1);
        start0(1'b1, t0);
        finish0("bp", t0, 1'b1, 4000, lat);

        // Every byte wrong: error count reaches its 256 maximum.
        rmode0 = 0;
        for (int i = 0; i < 256; i++) mem0[i] = ~8'(i);
        prep0(1'b1);
        start0(1'b1, t0);
        finish0("all_err", t0, 1'b1, 2000, lat);

        // Random images, random verify mode, random backpressure.
        rmode0 = 2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) mem0[i] = 8'($urandom);
            ver = 1'($urandom_range(0, 1));
            prep0(ver);
            start0(ver, t0);
            finish0("rand", t0, ver, 4000, lat);
        end

        // Abort while byte 100 is being offered.
        for (int i = 0; i < 256; i++) mem0[i] = 8'(i);
        rmode0 = 3;
        prep0(1'b1);
        start0(1'b1, t0);
        n = 0;
        while (!(if0.out_valid && if0.out_data == 8'd100) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_100", 32'(if0.out_valid && if0.out_data == 8'd100), 1);
        @(posedge clk); #1;
        if0.start_flag = 1'b0;
        @(posedge clk); #1;
        s = 0;
        for (int i = 0; i <= 100; i++) s += int'(mem0[i]);
        chk("abort_out_valid", 32'(if0.out_valid), 0);
        chk("abort_busy",      32'(if0.busy), 0);
        chk("abort_done",      32'(if0.done_flag), 0);
        chk("abort_address",   32'(if0.address), 0);
        chk("abort_sum_held",  32'(if0.checksum), s % 256);
        chk("abort_bytes",     bytes0, 100);
        chk("abort_queue",     exp0.size(), 156);

        // Restart after abort.
        rmode0 = 0;
        prep0(1'b1);
        start0(1'b1, t0);
        finish0("restart", t0, 1'b1, 2000, lat);

        // Asynchronous reset in the middle of a WAIT phase.
        prep0(1'b1);
        start0(1'b1, t0);
        n = 0;
        while (!(if0.busy && !if0.out_valid && if0.out_data >= 8'd20) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_wait", 32'(if0.busy && !if0.out_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk_zero0("async_rst");
        @(posedge clk); #1;
        chk("async_rst_hold_addr", 32'(if0.address), 0);
        prep0(1'b1);
        reset = 1'b0;
        t0 = cyc;
        finish0("post_rst", t0, 1'b1, 2000, lat);
        chk("post_rst_latency", lat, 768);

        // RD_LAT=2 instance, identity image.
        exp1.delete();
        s = 0;
        for (int i = 0; i < 256; i++) begin
            exp1.push_back(mem1[i]);
            s += int'(mem1[i]);
        end
        @(posedge clk); #1;
        if1.verify_en  = 1'b1;
        if1.start_flag = 1'b1;
        t0 = cyc;
        n = 0;
        while (!if1.done_flag && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("lat2_done_seen", 32'(if1.done_flag), 1);
        chk("lat2_latency",   cyc - t0 - 1, 1024);
        chk("lat2_checksum",  32'(if1.checksum), s % 256);
        chk("lat2_err_count", 32'(if1.err_count), 0);
        chk("lat2_bytes",     bytes1, 256);
        chk("lat2_queue",     exp1.size(), 0);
        @(posedge clk); #1;
        if1.start_flag = 1'b0;

        chk("wren_never_high", 32'(wren_hi), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
